// File: rtl/mem_stage.sv
// Memory-access stage: accepts EX results, performs byte-steered load/store on a
// req/ack data port and emits one writeback record per instruction. Optional: MEM_MISALIGN_TRAP_EN.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_store_data,
    input  logic [6:0]  ex_opcode,
    input  logic [2:0]  ex_funct3,
    input  logic [4:0]  ex_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        bus_timeout,
    output logic        misalign_trap
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {IDLE, BUSY, WB} state_t;

    state_t      state_q, state_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic [3:0]  dmem_be_q, dmem_be_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_we_q, wb_we_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        bus_timeout_q, bus_timeout_d;
    logic        misalign_trap_q, misalign_trap_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  ld_f3_q, ld_f3_d;
    logic [1:0]  off_q, off_d;

    logic        accept, is_load, is_store, mem_ok, writes, misal, do_bus;
    logic [1:0]  off, off_eff;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    assign ex_ready = (state_q != BUSY);
    assign accept   = ex_valid && ex_ready;
    assign is_load  = (ex_opcode == OPC_LOAD);
    assign is_store = (ex_opcode == OPC_STORE);
    assign off      = ex_result[1:0];
    assign writes   = (ex_opcode == OPC_OP) || (ex_opcode == OPC_OPIMM) ||
                      (ex_opcode == OPC_LUI) || (ex_opcode == OPC_AUIPC) ||
                      (ex_opcode == OPC_JAL) || (ex_opcode == OPC_JALR);
    assign misal    = ((ex_funct3[1:0] == 2'b01) && off[0]) ||
                      ((ex_funct3[1:0] == 2'b10) && (off != 2'b00));

    always_comb begin
        mem_ok = 1'b0;
        if (is_load)
            mem_ok = (ex_funct3 != 3'b011) && (ex_funct3[2:1] != 2'b11);
        else if (is_store)
            mem_ok = (ex_funct3[2] == 1'b0) && (ex_funct3[1:0] != 2'b11);
    end

    // Aligned accesses are unaffected; misaligned ones are aligned down when not trapped.
    always_comb begin
        case (ex_funct3[1:0])
            2'b01:   off_eff = {off[1], 1'b0};
            2'b10:   off_eff = 2'b00;
            default: off_eff = off;
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign do_bus        = mem_ok && !misal;
    assign misalign_trap = misalign_trap_q;
`else
    assign do_bus        = mem_ok;
    assign misalign_trap = 1'b0;
`endif

    always_comb begin
        case (off_q)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (ld_f3_q)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_val = {24'd0, ld_byte};
            3'b101:  ld_val = {16'd0, ld_half};
            default: ld_val = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        dmem_req_d      = dmem_req_q;
        dmem_we_d       = dmem_we_q;
        dmem_addr_d     = dmem_addr_q;
        dmem_wdata_d    = dmem_wdata_q;
        dmem_be_d       = dmem_be_q;
        wb_valid_d      = 1'b0;
        wb_we_d         = wb_we_q;
        wb_rd_d         = wb_rd_q;
        wb_data_d       = wb_data_q;
        bus_timeout_d   = 1'b0;
        misalign_trap_d = 1'b0;
        cnt_d           = cnt_q;
        ld_f3_d         = ld_f3_q;
        off_d           = off_q;
        if (state_q == BUSY) begin
            if (dmem_ack) begin
                state_d    = WB;
                dmem_req_d = 1'b0;
                wb_valid_d = 1'b1;
                wb_we_d    = !dmem_we_q && (wb_rd_q != 5'd0);
                wb_data_d  = dmem_we_q ? 32'd0 : ld_val;
            end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES - 1)) begin
                state_d       = WB;
                dmem_req_d    = 1'b0;
                wb_valid_d    = 1'b1;
                wb_we_d       = 1'b0;
                wb_data_d     = '0;
                bus_timeout_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end else if (accept) begin
            wb_rd_d = ex_rd;
            if (do_bus) begin
                state_d      = BUSY;
                dmem_req_d   = 1'b1;
                dmem_we_d    = is_store;
                dmem_addr_d  = {ex_result[31:2], 2'b00};
                cnt_d        = '0;
                ld_f3_d      = ex_funct3;
                off_d        = off_eff;
                case (ex_funct3[1:0])
                    2'b00: begin
                        dmem_be_d    = 4'b0001 << off_eff;
                        dmem_wdata_d = {4{ex_store_data[7:0]}};
                    end
                    2'b01: begin
                        dmem_be_d    = 4'b0011 << off_eff;
                        dmem_wdata_d = {2{ex_store_data[15:0]}};
                    end
                    default: begin
                        dmem_be_d    = '1;
                        dmem_wdata_d = ex_store_data;
                    end
                endcase
            end else begin
                state_d         = WB;
                wb_valid_d      = 1'b1;
                wb_we_d         = writes && (ex_rd != 5'd0);
                wb_data_d       = writes ? ex_result : 32'd0;
                misalign_trap_d = mem_ok && misal;
            end
        end else if (state_q == WB) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            dmem_req_q      <= 1'b0;
            dmem_we_q       <= 1'b0;
            dmem_addr_q     <= '0;
            dmem_wdata_q    <= '0;
            dmem_be_q       <= '0;
            wb_valid_q      <= 1'b0;
            wb_we_q         <= 1'b0;
            wb_rd_q         <= '0;
            wb_data_q       <= '0;
            bus_timeout_q   <= 1'b0;
            misalign_trap_q <= 1'b0;
            cnt_q           <= '0;
            ld_f3_q         <= '0;
            off_q           <= '0;
        end else begin
            state_q         <= state_d;
            dmem_req_q      <= dmem_req_d;
            dmem_we_q       <= dmem_we_d;
            dmem_addr_q     <= dmem_addr_d;
            dmem_wdata_q    <= dmem_wdata_d;
            dmem_be_q       <= dmem_be_d;
            wb_valid_q      <= wb_valid_d;
            wb_we_q         <= wb_we_d;
            wb_rd_q         <= wb_rd_d;
            wb_data_q       <= wb_data_d;
            bus_timeout_q   <= bus_timeout_d;
            misalign_trap_q <= misalign_trap_d;
            cnt_q           <= cnt_d;
            ld_f3_q         <= ld_f3_d;
            off_q           <= off_d;
        end
    end

    assign dmem_req    = dmem_req_q;
    assign dmem_we     = dmem_we_q;
    assign dmem_addr   = dmem_addr_q;
    assign dmem_wdata  = dmem_wdata_q;
    assign dmem_be     = dmem_be_q;
    assign wb_valid    = wb_valid_q;
    assign wb_we       = wb_we_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign bus_timeout = bus_timeout_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage directly downstream of the execute stage. It accepts one retired ALU result per handshake. It performs load/store accesses on a req/ack data-memory port, with byte-lane steering and load sign/zero extension. It presents one writeback record per instruction to the register-file write port.

Parameters:
TIMEOUT_CYCLES, 16, cycles dmem_req may stay high without dmem_ack before abort; 0 disables the timeout.

Ports:
clk  input  1  stage clock
reset  input  1  asynchronous active-high reset
ex_valid  input  1  EX presents an instruction
ex_ready  output  1  stage can accept; combinational, 0 only in BUSY
ex_result  input  32  ALU result; effective address for loads/stores
ex_store_data  input  32  rs2 value for stores
ex_opcode  input  7  instruction opcode
ex_funct3  input  3  width/sign select
ex_rd  input  5  destination register
dmem_req  output  1  access request, held until ack or abort
dmem_we  output  1  1 = store
dmem_addr  output  32  word-aligned address {addr[31:2],2'b00}
dmem_wdata  output  32  lane-replicated store data
dmem_be  output  4  byte enables
dmem_ack  input  1  access complete; rdata valid on loads
dmem_rdata  input  32  load word
wb_valid  output  1  one-cycle pulse per retired instruction
wb_we  output  1  write register file
wb_rd  output  5  destination register
wb_data  output  32  writeback value
bus_timeout  output  1  one-cycle pulse with wb_valid on timeout abort
misalign_trap  output  1  see Optional Feature

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. On reset, state goes to IDLE and every registered output clears to 0. ex_ready is therefore 1 out of reset. An in-flight access is abandoned and dmem_req drops immediately.
- Opcode classes:
  - LOAD 0000011 and STORE 0100011 are memory ops.
  - OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111, JAL 1101111 and JALR 1100111 write ex_result.
  - All other opcodes retire with wb_we=0.
- wb_we is forced to 0 when rd=0.
- FSM states: IDLE, BUSY, WB.
  - Accept occurs when ex_valid && ex_ready.
  - A non-memory op accepted goes to WB. wb_valid is 1 the next cycle: latency 1.
  - A memory op accepted goes to BUSY. dmem_req is 1 from the next cycle.
  - In BUSY, dmem_ack sampled high takes the stage to WB. wb_valid is 1 the following cycle, so minimum memory latency is 2. The request/ack cycle is ack-same-cycle.
  - WB with no accept returns to IDLE. WB with an accept follows the same transitions as IDLE, giving a back-to-back non-memory throughput of 1 per cycle.
- Byte steering, with off = addr[1:0]:
  - SB: be = 0001<<off, wdata = {4{data[7:0]}}.
  - SH: be = 0011<<off, wdata = {2{data[15:0]}}.
  - SW: be = 1111.
  - Loads use the same be.
- Load extraction from dmem_rdata at the off lane:
  - LB 000 and LH 001 sign-extend.
  - LW 010 takes the full word.
  - LBU 100 and LHU 101 zero-extend.
- Invalid memory funct3 (LOAD 011/110/111, STORE 011-111): no bus access. Retire via WB with wb_we=0.
- Stores retire with wb_we=0, wb_data=0.
- dmem_addr, dmem_we, dmem_be and dmem_wdata stay stable while dmem_req=1.
- Timeout:
  - The counter starts at dmem_req rise.
  - Reaching TIMEOUT_CYCLES without ack drops dmem_req and retires via WB with wb_we=0 and bus_timeout=1.
  - If ack arrives in the expiry cycle, ack wins.
- Misalignment: LH/LHU/SH with off[0]=1; LW/SW with off!=0.

Optional Feature:
Macro: MEM_MISALIGN_TRAP_EN
- Defined: a misaligned access issues no bus request. It retires one cycle after accept with wb_we=0 and misalign_trap=1, coincident with wb_valid.
- Undefined: misalign_trap is tied 0. The address is aligned down (half: off[0] cleared; word: off cleared) and the access proceeds normally.

Test Plan:
- Reset mid-BUSY: assert reset with dmem_req=1 -> dmem_req=0 at once; wb_valid=0; ex_ready=1 after release.
- Back-to-back ADD results 5 then 7, rd=3 then rd=4, no gaps -> wb_valid high 2 consecutive cycles; wb_data 5 then 7; wb_we=1.
- SB at addr 0x103, data 0xAABBCCDD -> dmem_addr=0x100, be=1000, wdata=0xDDDDDDDD; store retires with wb_we=0.
- LB at addr 0x102 with rdata 0x00800000 -> wb_data=0xFFFFFF80. LBU at the same address -> 0x00000080. Ack delayed 3 cycles -> dmem_req held 3 cycles.
- No ack with TIMEOUT_CYCLES=4 -> dmem_req drops after 4 cycles; bus_timeout=1 with wb_valid; wb_we=0.
- LW at 0x102:
  - With MEM_MISALIGN_TRAP_EN: no dmem_req; misalign_trap=1.
  - Without it: dmem_addr=0x100, be=1111.
